id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 76 +++++++
 rtl/id_regfile.sv | 47 ++++
 rtl/id_stage.sv | 119 +++++++++++
 tb/tb_id_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcodes, error codes,
// immediate formats and the layout of the stage output register.
package id_stage_pkg;

  localparam int CORE_ERROR_WIDTH = 2;

  localparam logic [CORE_ERROR_WIDTH-1:0] CORE_ERROR_NO = 2'd0;
  localparam logic [CORE_ERROR_WIDTH-1:0] CORE_ERROR_IF = 2'd1;
  localparam logic [CORE_ERROR_WIDTH-1:0] CORE_ERROR_ID = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } imm_fmt_e;

  typedef struct packed {
    logic                        nop_statue;
    logic [CORE_ERROR_WIDTH-1:0] error_code;
    logic [31:0]                 rs1_data;
    logic [31:0]                 rs2_data;
    logic [31:0]                 imm;
    logic [31:0]                 pc_out;
    logic [4:0]                  rd;
    logic [6:0]                  opcode;
    logic [2:0]                  funct3;
    logic                        funct7_5;
  } id_out_t;

  function automatic imm_fmt_e opcode_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP:                         return FMT_R;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: return FMT_I;
      OPC_STORE:                      return FMT_S;
      OPC_BRANCH:                     return FMT_B;
      OPC_LUI, OPC_AUIPC:             return FMT_U;
      OPC_JAL:                        return FMT_J;
      default:                        return FMT_BAD;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'h000};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // A bubble carries no operands; only the error code distinguishes kinds.
  function automatic id_out_t bubble(input logic [CORE_ERROR_WIDTH-1:0] err);
    id_out_t b;
    b            = '0;
    b.nop_statue = 1'b1;
    b.error_code = err;
    return b;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hard-wired to zero, optional same-cycle writeback forwarding.
module id_regfile #(
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic        clk,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  // No reset on storage; x0 has no cell at all.
  logic [31:0] mem [1:31];

  always_ff @(posedge clk) begin
    if (wb_en && wb_rd != 5'd0) begin
      mem[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (BYPASS_WB && wb_en && wb_rd == rs1_addr) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = mem[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (BYPASS_WB && wb_en && wb_rd == rs2_addr) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = mem[rs2_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: field extraction, immediate generation,
// register read, load-use hazard detection and a one-cycle output register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        nop,
  input  logic [31:0]                 instruction,
  input  logic [31:0]                 pc_in,
  input  logic                        nop_in,
  input  logic [CORE_ERROR_WIDTH-1:0] error_in,
  input  logic                        wb_en,
  input  logic [4:0]                  wb_rd,
  input  logic [31:0]                 wb_data,
  output logic                        done,
  output logic                        stall_req,
  output logic [31:0]                 rs1_data,
  output logic [31:0]                 rs2_data,
  output logic [31:0]                 imm,
  output logic [31:0]                 pc_out,
  output logic [4:0]                  rd,
  output logic [6:0]                  opcode,
  output logic [2:0]                  funct3,
  output logic                        funct7_5,
  output logic                        nop_statue,
  output logic [CORE_ERROR_WIDTH-1:0] error_code
);

  logic [6:0]  in_opc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  imm_fmt_e    in_fmt;
  logic        in_legal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  id_out_t     q;
  id_out_t     d;

  assign in_opc   = instruction[6:0];
  assign in_rd    = instruction[11:7];
  assign in_rs1   = instruction[19:15];
  assign in_rs2   = instruction[24:20];
  assign in_fmt   = opcode_fmt(in_opc);
  assign in_legal = (instruction[1:0] == 2'b11) && (in_fmt != FMT_BAD);
  assign uses_rs1 = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign uses_rs2 = in_fmt inside {FMT_R, FMT_S, FMT_B};

  id_regfile #(
    .BYPASS_WB (BYPASS_WB)
  ) u_regfile (
    .clk      (clk),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rs1_addr (in_rs1),
    .rs2_addr (in_rs2),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2)
  );

  // Handshake: enable offers the fetch-stage instruction; done=enable&~stall_req
  // means it was consumed this cycle. While stall_req is high fetch must hold
  // instruction/pc_in steady; the stage inserts a bubble in the meantime.
  assign stall_req = (q.opcode == OPC_LOAD) && !q.nop_statue && (q.rd != 5'd0) && !nop_in &&
                     ((uses_rs1 && q.rd == in_rs1) || (uses_rs2 && q.rd == in_rs2));
  assign done      = enable & ~stall_req;

  always_comb begin
    d = bubble(CORE_ERROR_NO);
    if (nop || stall_req) begin
      d = bubble(CORE_ERROR_NO);
    end else if (error_in != CORE_ERROR_NO) begin
      d = bubble(error_in);
    end else if (nop_in) begin
      d = bubble(CORE_ERROR_NO);
    end else if (!in_legal) begin
      d = bubble(CORE_ERROR_ID);
    end else begin
      d.nop_statue = 1'b0;
      d.error_code = CORE_ERROR_NO;
      d.rs1_data   = rf_rs1;
      d.rs2_data   = rf_rs2;
      d.imm        = gen_imm(instruction, in_fmt);
      d.pc_out     = pc_in;
      // Stores and branches have no destination; their rd bits are immediate.
      d.rd         = (in_fmt inside {FMT_S, FMT_B}) ? 5'd0 : in_rd;
      d.opcode     = in_opc;
      d.funct3     = instruction[14:12];
      d.funct7_5   = instruction[30];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= bubble(CORE_ERROR_NO);
    end else if (enable) begin
      q <= d;
    end
  end

  assign rs1_data   = q.rs1_data;
  assign rs2_data   = q.rs2_data;
  assign imm        = q.imm;
  assign pc_out     = q.pc_out;
  assign rd         = q.rd;
  assign opcode     = q.opcode;
  assign funct3     = q.funct3;
  assign funct7_5   = q.funct7_5;
  assign nop_statue = q.nop_statue;
  assign error_code = q.error_code;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: behavioural decode model compared every
// cycle, directed scenarios pinned with literal values, then random traffic.
module tb_id_stage;
  import id_stage_pkg::*;

  logic                        clk;
  logic                        reset;
  logic                        enable;
  logic                        nop;
  logic [31:0]                 instruction;
  logic [31:0]                 pc_in;
  logic                        nop_in;
  logic [CORE_ERROR_WIDTH-1:0] error_in;
  logic                        wb_en;
  logic [4:0]                  wb_rd;
  logic [31:0]                 wb_data;
  logic                        done;
  logic                        stall_req;
  logic [31:0]                 rs1_data;
  logic [31:0]                 rs2_data;
  logic [31:0]                 imm;
  logic [31:0]                 pc_out;
  logic [4:0]                  rd;
  logic [6:0]                  opcode;
  logic [2:0]                  funct3;
  logic                        funct7_5;
  logic                        nop_statue;
  logic [CORE_ERROR_WIDTH-1:0] error_code;

  int n_checks = 0;
  int n_pass   = 0;

  id_stage #(
    .BYPASS_WB (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .nop         (nop),
    .instruction (instruction),
    .pc_in       (pc_in),
    .nop_in      (nop_in),
    .error_in    (error_in),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .done        (done),
    .stall_req   (stall_req),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .pc_out      (pc_out),
    .rd          (rd),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .nop_statue  (nop_statue),
    .error_code  (error_code)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]                 m_rf [32];
  logic                        e_nop;
  logic [CORE_ERROR_WIDTH-1:0] e_err;
  logic [31:0]                 e_rs1, e_rs2, e_imm, e_pc;
  logic [4:0]                  e_rd;
  logic [6:0]                  e_opcode;
  logic [2:0]                  e_funct3;
  logic                        e_f7;

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] top;
    top = 32'd1 << (n - 1);
    return (v ^ top) - top;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    case (w[6:0])
      7'h37, 7'h17:        return {w[31:12], 12'h000};
      7'h6F:               return sext({11'h0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      7'h67, 7'h03, 7'h13: return sext({20'h0, w[31:20]}, 12);
      7'h23:               return sext({20'h0, w[31:25], w[11:7]}, 12);
      7'h63:               return sext({19'h0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      default:             return 32'h0;
    endcase
  endfunction

  // The registered instruction is a live load whose destination the incoming one reads.
  function automatic logic m_stall();
    logic hit1, hit2;
    hit1 = reads_rs1(instruction[6:0]) && (e_rd == instruction[19:15]);
    hit2 = reads_rs2(instruction[6:0]) && (e_rd == instruction[24:20]);
    return (e_opcode == 7'h03) && !e_nop && (e_rd != 0) && !nop_in && (hit1 || hit2);
  endfunction

  task automatic set_bubble(input logic [CORE_ERROR_WIDTH-1:0] err);
    e_nop = 1'b1; e_err = err; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_pc = 0;
    e_rd = 0; e_opcode = 0; e_funct3 = 0; e_f7 = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    logic stall_now;
    if (reset) begin
      set_bubble(CORE_ERROR_NO);
    end else begin
      stall_now = m_stall();
      // With forwarding, a same-cycle writeback is already visible to this read.
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
      if (enable) begin
        if (nop || stall_now) set_bubble(CORE_ERROR_NO);
        else if (error_in != CORE_ERROR_NO) set_bubble(error_in);
        else if (nop_in) set_bubble(CORE_ERROR_NO);
        else if (instruction[1:0] != 2'b11 || !legal_op(instruction[6:0])) set_bubble(CORE_ERROR_ID);
        else begin
          e_nop    = 1'b0;
          e_err    = CORE_ERROR_NO;
          e_rs1    = (instruction[19:15] == 0) ? 32'h0 : m_rf[instruction[19:15]];
          e_rs2    = (instruction[24:20] == 0) ? 32'h0 : m_rf[instruction[24:20]];
          e_imm    = m_imm(instruction);
          e_pc     = pc_in;
          e_rd     = (instruction[6:0] == 7'h23 || instruction[6:0] == 7'h63) ? 5'd0 : instruction[11:7];
          e_opcode = instruction[6:0];
          e_funct3 = instruction[14:12];
          e_f7     = instruction[30];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("nop_statue", nop_statue, e_nop);
    chk("error_code", error_code, e_err);
    chk("rs1_data",   rs1_data,   e_rs1);
    chk("rs2_data",   rs2_data,   e_rs2);
    chk("imm",        imm,        e_imm);
    chk("pc_out",     pc_out,     e_pc);
    chk("rd",         rd,         e_rd);
    chk("opcode",     opcode,     e_opcode);
    chk("funct3",     funct3,     e_funct3);
    chk("funct7_5",   funct7_5,   e_f7);
    chk("stall_req",  stall_req,  m_stall());
    chk("done",       done,       enable & ~m_stall());
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 0; nop = 0; nop_in = 0; error_in = CORE_ERROR_NO; wb_en = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] pc);
    enable = 1; instruction = w; pc_in = pc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:       w[6:0] = 7'h37;
      1:       w[6:0] = 7'h17;
      2:       w[6:0] = 7'h6F;
      3:       w[6:0] = 7'h67;
      4:       w[6:0] = 7'h63;
      5, 10:   w[6:0] = 7'h03;
      6:       w[6:0] = 7'h23;
      7:       w[6:0] = 7'h13;
      8, 11:   w[6:0] = 7'h33;
      default: w[6:0] = 7'($urandom);
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    reset = 1; instruction = 0; pc_in = 0;
    idle();
    tick();
    chk("reset nop_statue", nop_statue, 1);
    chk("reset error_code", error_code, CORE_ERROR_NO);
    chk("reset rd",         rd,         0);
    chk("reset imm",        imm,        0);
    reset = 0;

    // Give every register a known value before anything reads it.
    for (int r = 1; r < 32; r++) begin
      wb_en = 1; wb_rd = 5'(r); wb_data = $urandom;
      tick();
    end
    idle();

    issue(32'hABCDE0B7, 32'h0000_0100);
    tick();
    chk("lui opcode", opcode, 32'h37);
    chk("lui rd",     rd,     1);
    chk("lui imm",    imm,    32'hABCDE000);
    chk("lui nop",    nop_statue, 0);

    idle(); wb_en = 1; wb_rd = 5; wb_data = 32'h12345678;
    tick();
    idle(); issue(32'hFFF28313, 32'h0000_0104);
    tick();
    chk("addi rs1_data", rs1_data, 32'h12345678);
    chk("addi imm",      imm,      32'hFFFFFFFF);
    chk("addi rd",       rd,       6);

    idle(); wb_en = 1; wb_rd = 5; wb_data = 32'h0;
    tick();
    issue(32'hFFF28313, 32'h0000_0108); wb_en = 1; wb_rd = 5; wb_data = 32'h12345678;
    tick();
    chk("bypass rs1_data", rs1_data, 32'h12345678);
    chk("bypass imm",      imm,      32'hFFFFFFFF);

    idle(); issue(32'h0000A383, 32'h0000_0200);
    tick();
    chk("lw opcode", opcode, 32'h03);
    chk("lw rd",     rd,     7);
    issue(32'h00238433, 32'h0000_0204);
    #1;
    chk("load-use stall", stall_req, 1);
    chk("load-use done",  done,      0);
    tick();
    chk("bubble nop",     nop_statue, 1);
    chk("bubble rd",      rd,         0);
    chk("after stall",    stall_req,  0);
    chk("after done",     done,       1);
    tick();
    chk("add rd",     rd,         8);
    chk("add opcode", opcode,     32'h33);
    chk("add nop",    nop_statue, 0);

    for (int k = 0; k < 3; k++) begin
      enable = 0; instruction = rand_inst();
      tick();
    end
    chk("hold rd",     rd,     8);
    chk("hold opcode", opcode, 32'h33);

    issue(32'hFFF28313, 32'h0000_0300); nop = 1;
    tick();
    chk("flush nop",    nop_statue, 1);
    chk("flush rd",     rd,         0);
    chk("flush opcode", opcode,     0);
    nop = 0;

    issue(32'h0000007F, 32'h0000_0400);
    tick();
    chk("bad opcode err", error_code, CORE_ERROR_ID);
    chk("bad opcode nop", nop_statue, 1);
    issue(32'h00000010, 32'h0000_0404);
    tick();
    chk("bad low bits err", error_code, CORE_ERROR_ID);
    issue(32'hFFF28313, 32'h0000_0408); error_in = CORE_ERROR_IF;
    tick();
    chk("fetch err", error_code, CORE_ERROR_IF);
    chk("fetch nop", nop_statue, 1);
    error_in = CORE_ERROR_NO;
    issue(32'h0000007F, 32'h0000_040C); nop_in = 1;
    tick();
    chk("nop_in err", error_code, CORE_ERROR_NO);
    chk("nop_in nop", nop_statue, 1);
    nop_in = 0;

    idle(); wb_en = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    tick();
    issue(32'h00100313, 32'h0000_0500); wb_en = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    tick();
    chk("x0 rs1_data", rs1_data, 0);
    chk("x0 imm",      imm,      1);

    idle(); issue(32'hABCDE0B7, 32'h0000_0600);
    tick();
    reset = 1;
    #1;
    chk("async reset nop",    nop_statue, 1);
    chk("async reset opcode", opcode,     0);
    chk("async reset imm",    imm,        0);
    chk("async reset pc",     pc_out,     0);
    #1;
    reset = 0; idle();
    tick();

    for (int c = 0; c < 800; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      nop      = ($urandom_range(0, 19) == 0);
      nop_in   = ($urandom_range(0, 9) == 0);
      error_in = ($urandom_range(0, 19) == 0) ? CORE_ERROR_IF : CORE_ERROR_NO;
      if (!m_stall() || $urandom_range(0, 3) == 0) instruction = rand_inst();
      pc_in    = $urandom;
      wb_en    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
